// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder step per clock, LSB first, with an IDLE/RUN/DONE
// controller that latches the sum and carry-out when the last bit is processed.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;

    logic             fa_sum, fa_carry;
    logic [WIDTH-1:0] sum_nxt;

    assign fa_sum   = a_q[0] ^ b_q[0] ^ c_q;
    assign fa_carry = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));

    // Sum bits enter at the MSB so that after WIDTH steps the word is aligned.
    if (WIDTH == 1) begin : g_w1
        assign sum_nxt = fa_sum;
    end else begin : g_wn
        assign sum_nxt = {fa_sum, sum_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sum_d    = sum_q;
        c_d      = c_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        cout_d   = cout_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    c_d     = cin;
                    sum_d   = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                sum_d = sum_nxt;
                c_d   = fa_carry;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    result_d = sum_nxt;
                    cout_d   = fa_carry;
                    state_d  = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            c_q      <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sum_q    <= sum_d;
            c_q      <= c_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            cout_q   <= cout_d;
        end
    end

    assign busy   = (state_q == S_RUN);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign cout   = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboarded bench: stimulus pushes expected sums with their due cycle, a negedge
// monitor pops one entry per done pulse; a second instance covers WIDTH=1.
module tb_serial_adder_ctrl;

    logic       clk, rst_n;
    logic       start, cin;
    logic [7:0] op_a, op_b;
    logic       busy, done, cout;
    logic [7:0] result;

    logic       start1, a1, b1, cin1;
    logic       busy1, done1, cout1;
    logic [0:0] result1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [7:0] res;
        logic       co;
        int         due;
    } exp_t;
    exp_t sb[$];

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b), .cin(cin),
        .busy(busy), .done(done), .result(result), .cout(cout)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .op_a(a1), .op_b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .result(result1), .cout(cout1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", {24'd0, result}, {24'd0, e.res});
                chk("cout", {31'd0, cout}, {31'd0, e.co});
                chk("latency", cyc, e.due);
            end
        end
    end

    // Call at a negedge; start is sampled at the next posedge (edge cyc+1).
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic c,
                         input bit push, input logic [7:0] er, input logic ec);
        exp_t e;
        op_a  = a;
        op_b  = b;
        cin   = c;
        start = 1'b1;
        if (push) begin
            e.res = er;
            e.co  = ec;
            e.due = cyc + 1 + 8;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
        start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", {24'd0, result}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(2);

        // Zero operands, with busy duration measured.
        issue(8'h00, 8'h00, 1'b0, 1, 8'h00, 1'b0);
        n = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (busy) n++;
            @(negedge clk);
        end
        chk("busy_cycles", n, 32'd8);
        idle(2);

        issue(8'hFF, 8'h01, 1'b0, 1, 8'h00, 1'b1); idle(11);
        issue(8'hFF, 8'hFF, 1'b1, 1, 8'hFF, 1'b1); idle(11);
        issue(8'h5A, 8'h33, 1'b0, 1, 8'h8D, 1'b0); idle(11);

        // Start during RUN (edge k+3) must be ignored.
        issue(8'h12, 8'h34, 1'b0, 1, 8'h46, 1'b0);
        idle(2);
        op_a = 8'hFF; op_b = 8'hFF; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        idle(10);

        // Reset mid-RUN: operation abandoned, no done pulse.
        issue(8'hF0, 8'h0F, 1'b0, 0, 8'h00, 1'b0);
        idle(3);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_result", {24'd0, result}, 32'd0);
        chk("midrst_cout", {31'd0, cout}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(12);
        issue(8'h01, 8'h01, 1'b0, 1, 8'h02, 1'b0); idle(11);

        // Back-to-back: new start presented in the DONE cycle.
        issue(8'h11, 8'h22, 1'b0, 1, 8'h33, 1'b0);
        idle(8);
        chk("b2b_done_first", {31'd0, done}, 32'd1);
        issue(8'h80, 8'h80, 1'b0, 1, 8'h00, 1'b1);
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        chk("b2b_done_low", {31'd0, done}, 32'd0);
        idle(11);

        // WIDTH=1 instance: done one edge after acceptance.
        start1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk("w1_busy", {31'd0, busy1}, 32'd1);
        chk("w1_done_early", {31'd0, done1}, 32'd0);
        @(negedge clk);
        chk("w1_done", {31'd0, done1}, 32'd1);
        chk("w1_result", {31'd0, result1}, 32'd1);
        chk("w1_cout", {31'd0, cout1}, 32'd1);
        @(negedge clk);
        chk("w1_done_pulse", {31'd0, done1}, 32'd0);
        start1 = 1'b1; a1 = 1'b1; b1 = 1'b0; cin1 = 1'b0;
        @(negedge clk);
        start1 = 1'b0;
        @(negedge clk);
        chk("w1b_result", {31'd0, result1}, 32'd1);
        chk("w1b_cout", {31'd0, cout1}, 32'd0);
        idle(2);

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, sets the operand and result width in bits; legal range 1..32.
REQ-002 The design SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request to begin one addition; sampled on the rising edge of clk.
REQ-006 op_a  input  WIDTH  addend A; captured only on an accepted start.
REQ-007 op_b  input  WIDTH  addend B; captured only on an accepted start.
REQ-008 cin  input  1  carry-in; captured only on an accepted start.
REQ-009 busy  output  1  high while bits are being processed (RUN state).
REQ-010 done  output  1  one-cycle pulse; result and cout are valid and updated.
REQ-011 result  output  WIDTH  registered sum of the last completed addition.
REQ-012 cout  output  1  registered carry-out of the last completed addition.

Function
REQ-013 The block SHALL compute op_a + op_b + cin bit-serially, LSB first, using exactly one 1-bit full-adder function per clock cycle.
  - sum = a ^ b ^ c
  - carry = (a & b) | (c & (a ^ b))
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE, encoded in registers.
REQ-015 A start seen in IDLE or DONE is accepted at that edge. The block SHALL then:
  - capture op_a and op_b into internal shift registers;
  - load the carry register with cin;
  - clear the bit counter;
  - go to RUN.
REQ-016 A start seen in RUN SHALL be ignored: no capture, no state change, no effect on the operation in progress.
REQ-017 On each RUN edge the block SHALL:
  - take the operand LSBs and the carry register as full-adder inputs;
  - shift the sum bit into the MSB of an internal sum shift register;
  - shift both operand registers right by one;
  - store the new carry;
  - increment the counter.
REQ-018 On the RUN edge that processes bit WIDTH-1, the block SHALL:
  - load result with the completed sum;
  - load cout with the final carry;
  - go to DONE.
REQ-019 Latency: with start accepted at edge k, done SHALL be high for exactly the cycle that follows edge k+WIDTH; result and cout SHALL be valid from that same edge.
REQ-020 From DONE with no start, the FSM SHALL return to IDLE on the next edge and deassert done.
REQ-021 From DONE with start high, the FSM SHALL go directly to RUN (back-to-back), and done SHALL deassert.
REQ-022 busy SHALL equal (state == RUN); done SHALL equal (state == DONE); neither output has combinational paths from inputs.
REQ-023 result and cout SHALL hold their last values through IDLE and through subsequent RUN phases until the next completion overwrites them.
REQ-024 Arithmetic SHALL be modulo 2^WIDTH in result, with the overflow bit in cout; the counter is ceil(log2(WIDTH+1)) bits wide and never wraps during an operation.
REQ-025 For WIDTH=1, RUN SHALL last one cycle; the REQ-019 timing holds with k+1.

Reset
REQ-026 While rst_n is low, the block SHALL force immediately, independent of clk:
  - state = IDLE
  - busy = 0, done = 0
  - result = 0, cout = 0
  - internal shift registers, carry register and counter = 0
REQ-027 Reset asserted mid-RUN SHALL abandon the operation. No done pulse SHALL occur, and result/cout SHALL read 0 after reset.
REQ-028 After rst_n deasserts, the first edge with start high SHALL be accepted normally.

Verification
REQ-029 WIDTH=8: op_a=0x00, op_b=0x00, cin=0 -> done at edge k+8; result=0x00, cout=0; busy high for 8 cycles.
REQ-030 WIDTH=8: 0xFF + 0x01, cin=0 -> result=0x00, cout=1. Then 0xFF + 0xFF, cin=1 -> result=0xFF, cout=1. Then 0x5A + 0x33, cin=0 -> result=0x8D, cout=0.
REQ-031 Start 0x12+0x34; pulse start with 0xFF/0xFF at edge k+3 -> ignored; done at k+8 with result=0x46, cout=0.
REQ-032 rst_n low at edge k+4 of 0xF0+0x0F -> busy=0, done=0, result=0x00 immediately; no done pulse; a new 0x01+0x01 afterwards yields 0x02.
REQ-033 Start held high across the DONE cycle with new operands 0x80+0x80 -> immediate re-entry to RUN; second done 8 edges later with result=0x00, cout=1; done high exactly one cycle each time.
REQ-034 WIDTH=1: a=1, b=1, cin=1 -> done one edge after acceptance; result=1, cout=1.
